// File: rtl/dual_slope_ctrl.sv
// Dual-slope ADC sequencer: fixed integrate on Vin, counted de-integrate on Vref until the comparator trips.
// Optional auto-zero phase before integration is enabled by defining DSC_AUTO_ZERO_EN.
module dual_slope_ctrl #(
    parameter int WIDTH       = 10,
    parameter int T_INT       = 1000,
    parameter int T_AZ        = 100,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_s,
    input  logic             start,
    input  logic             cmp,
    output logic             sw_vin,
    output logic             sw_vref,
    output logic             sw_az,
    output logic             int_rst,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overrange
);

    localparam logic [WIDTH-1:0] INT_LAST = WIDTH'(T_INT - 1);
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] CNT_FULL = '1;

`ifdef DSC_AUTO_ZERO_EN
    localparam logic [WIDTH-1:0] AZ_LAST = WIDTH'(T_AZ - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_AZ    = 3'd1,
        S_INTEG = 3'd2,
        S_DEINT = 3'd3,
        S_DONE  = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_INTEG = 2'd1,
        S_DEINT = 2'd2,
        S_DONE  = 2'd3
    } state_t;
`endif

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]       result_q, result_d;
    logic                   overrange_q, overrange_d;
    logic                   sw_vin_q, sw_vin_d;
    logic                   sw_vref_q, sw_vref_d;
    logic                   int_rst_q, int_rst_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [SYNC_STAGES-1:0] cmp_sync_q, cmp_sync_d;
    logic                   cmp_s;

    // The synchroniser delay is deliberately left in the count.
    assign cmp_s = cmp_sync_q[SYNC_STAGES-1];

    always_comb begin
        cmp_sync_d  = {cmp_sync_q[SYNC_STAGES-2:0], cmp};
        state_d     = state_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        overrange_d = overrange_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
`ifdef DSC_AUTO_ZERO_EN
                    state_d = S_AZ;
`else
                    state_d = S_INTEG;
`endif
                end
            end
`ifdef DSC_AUTO_ZERO_EN
            S_AZ: begin
                if (cnt_q == AZ_LAST) begin
                    state_d = S_INTEG;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
`endif
            S_INTEG: begin
                if (cnt_q == INT_LAST) begin
                    state_d = S_DEINT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_DEINT: begin
                // A comparator trip wins over full scale on the same cycle.
                if (!cmp_s) begin
                    result_d    = cnt_q;
                    overrange_d = 1'b0;
                    state_d     = S_DONE;
                end else if (cnt_q == CNT_FULL) begin
                    result_d    = CNT_FULL;
                    overrange_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Outputs are decoded from the next state so every output is a flop.
        sw_vin_d  = (state_d == S_INTEG);
        sw_vref_d = (state_d == S_DEINT);
        int_rst_d = (state_d == S_IDLE) || (state_d == S_DONE);
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
    end

`ifdef DSC_AUTO_ZERO_EN
    logic sw_az_q, sw_az_d;

    always_comb begin
        sw_az_d = (state_d == S_AZ);
    end

    always_ff @(posedge clk or posedge rst_s) begin
        if (rst_s) begin
            sw_az_q <= 1'b0;
        end else begin
            sw_az_q <= sw_az_d;
        end
    end

    assign sw_az = sw_az_q;
`else
    assign sw_az = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst_s) begin
        if (rst_s) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            result_q    <= '0;
            overrange_q <= 1'b0;
            sw_vin_q    <= 1'b0;
            sw_vref_q   <= 1'b0;
            int_rst_q   <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cmp_sync_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            overrange_q <= overrange_d;
            sw_vin_q    <= sw_vin_d;
            sw_vref_q   <= sw_vref_d;
            int_rst_q   <= int_rst_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cmp_sync_q  <= cmp_sync_d;
        end
    end

    assign sw_vin    = sw_vin_q;
    assign sw_vref   = sw_vref_q;
    assign int_rst   = int_rst_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign overrange = overrange_q;

endmodule

// File: tb/tb_dual_slope_ctrl.sv
// Bench for dual_slope_ctrl: directed conversions feed an expected queue; a negedge monitor
// checks every done pulse against it and checks the per-cycle switch/busy invariants.
module tb_dual_slope_ctrl;

    localparam int WIDTH       = 10;
    localparam int T_INT       = 1000;
    localparam int T_AZ        = 100;
    localparam int SYNC_STAGES = 2;
    // {deint_len[10:0], overrange, result[WIDTH-1:0]}
    localparam int EW          = 11 + 1 + WIDTH;

    logic             clk;
    logic             rst_s;
    logic             start;
    logic             cmp;
    logic             sw_vin;
    logic             sw_vref;
    logic             sw_az;
    logic             int_rst;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             overrange;

    logic [EW-1:0] exp_q[$];
    int            n_assert;
    int            n_fail;

    dual_slope_ctrl #(
        .WIDTH       (WIDTH),
        .T_INT       (T_INT),
        .T_AZ        (T_AZ),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk       (clk),
        .rst_s     (rst_s),
        .start     (start),
        .cmp       (cmp),
        .sw_vin    (sw_vin),
        .sw_vref   (sw_vref),
        .sw_az     (sw_az),
        .int_rst   (int_rst),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .overrange (overrange)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sw_vin"},    32'(sw_vin),    32'd0);
        check({tag, "_sw_vref"},   32'(sw_vref),   32'd0);
        check({tag, "_sw_az"},     32'(sw_az),     32'd0);
        check({tag, "_int_rst"},   32'(int_rst),   32'd1);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_done"},      32'(done),      32'd0);
        check({tag, "_result"},    32'(result),    32'd0);
        check({tag, "_overrange"}, 32'(overrange), 32'd0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    int vin_len;
    int vref_len;
    int az_len;

    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (rst_s) begin
            vin_len  = 0;
            vref_len = 0;
            az_len   = 0;
        end else begin
            check("switch_onehot", 32'($countones({sw_vin, sw_vref, sw_az}) <= 1), 32'd1);
            check("busy_phase", 32'(busy), 32'(sw_vin | sw_vref | sw_az | done));
            check("int_rst_phase", 32'(int_rst), 32'(!(sw_vin | sw_vref | sw_az)));
`ifndef DSC_AUTO_ZERO_EN
            check("sw_az_tied", 32'(sw_az), 32'd0);
`else
            if (sw_az) az_len++;
            else if (az_len != 0) begin
                check("az_len", 32'(az_len), 32'(T_AZ));
                az_len = 0;
            end
`endif
            if (sw_vin) vin_len++;
            else if (vin_len != 0) begin
                check("integ_len", 32'(vin_len), 32'(T_INT));
                vin_len = 0;
            end
            if (sw_vref) vref_len++;
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("result",    32'(result),    32'(e[WIDTH-1:0]));
                    check("overrange", 32'(overrange), 32'(e[WIDTH]));
                    check("deint_len", 32'(vref_len),  32'(e[EW-1:WIDTH+1]));
                end
                vref_len = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_exp(input int len, input logic ovr, input logic [WIDTH-1:0] res);
        logic [EW-1:0] e;
        e = {11'(len), ovr, res};
        exp_q.push_back(e);
    endtask

    // Issue start for one cycle and check the 1-clock latency to the first active switch.
    task automatic start_pulse();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
`ifdef DSC_AUTO_ZERO_EN
        check("start_latency_az", 32'(sw_az), 32'd1);
`else
        check("start_latency_vin", 32'(sw_vin), 32'd1);
`endif
    endtask

    task automatic wait_vref();
        int i;
        for (i = 0; i < 3000; i++) begin
            if (sw_vref) break;
            @(negedge clk);
        end
        if (i == 3000) check("wait_vref_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_done();
        int i;
        for (i = 0; i < 4000; i++) begin
            if (done) break;
            @(negedge clk);
        end
        if (i == 4000) check("wait_done_timeout", 32'd1, 32'd0);
    endtask

    // cmp falls d negedges after sw_vref is first seen high.
    task automatic conv_trip(input int d, input int exp_res);
        push_exp(exp_res + 1, 1'b0, WIDTH'(exp_res));
        cmp = 1'b1;
        start_pulse();
        wait_vref();
        repeat (d) @(negedge clk);
        cmp = 1'b0;
        wait_done();
        cmp = 1'b1;
        @(negedge clk);
    endtask

    typedef struct {
        int d;
        int exp_res;
    } trip_vec_t;

    trip_vec_t trip_vecs[4] = '{
        '{299,  301},
        '{0,    2},
        '{10,   12},
        '{1021, 1023}
    };

    // ---------------- main sequence ----------------
    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_s    = 1'b1;
        start    = 1'b0;
        cmp      = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        #2 rst_s = 1'b0;
        repeat (2) @(negedge clk);

        foreach (trip_vecs[i]) conv_trip(trip_vecs[i].d, trip_vecs[i].exp_res);

        // No trip at all: full scale after 1024 de-integrate cycles.
        push_exp(1024, 1'b1, '1);
        cmp = 1'b1;
        start_pulse();
        wait_done();
        @(negedge clk);
        check("overrange_held", 32'(overrange), 32'd1);
        check("result_held", 32'(result), 32'd1023);

        // Comparator already low before DEINT, start held for two conversions.
        cmp = 1'b0;
        push_exp(1, 1'b0, '0);
        push_exp(1, 1'b0, '0);
        start_pulse();
        start = 1'b1;
        wait_done();
        @(negedge clk);
        check("gap_idle_busy", 32'(busy), 32'd0);
        check("gap_idle_vin", 32'(sw_vin), 32'd0);
        @(negedge clk);
`ifdef DSC_AUTO_ZERO_EN
        check("b2b_restart", 32'(sw_az), 32'd1);
`else
        check("b2b_restart", 32'(sw_vin), 32'd1);
`endif
        start = 1'b0;
        wait_done();
        cmp = 1'b1;
        @(negedge clk);

        // start while busy is ignored: one pulse mid-INTEG must not queue a second conversion.
        push_exp(13, 1'b0, WIDTH'(12));
        start_pulse();
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_vref();
        repeat (10) @(negedge clk);
        cmp = 1'b0;
        wait_done();
        cmp = 1'b1;
        repeat (3) @(negedge clk);
        check("no_queued_start", 32'(busy), 32'd0);

        // Abort mid-DEINT.
        cmp = 1'b1;
        start_pulse();
        wait_vref();
        repeat (50) @(negedge clk);
        #2 rst_s = 1'b1;
        #1 check_reset_outputs("abort");
        @(negedge clk);
        #2 rst_s = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_no_done", 32'(done), 32'd0);

        // A full conversion still works after the abort.
        conv_trip(299, 301);

        repeat (5) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        n_assert++;
        n_fail++;
        $display("FAIL global_timeout: got running expected finished");
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
